// File: rtl/sd_bitmap_loader.sv
// Streams a run of consecutive SD blocks into the board RAM, unpacking each
// buffer byte into WORD_WIDTH-bit RAM words.
module sd_bitmap_loader #(
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned WORD_WIDTH     = 1,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter bit          LSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                           clk_spi,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [31:0]                    first_block,
    input  logic [15:0]                    num_blocks,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    output logic [31:0]                    blk_id,
    output logic                           blk_execute,
    input  logic                           blk_done,
    output logic [$clog2(BLOCK_BYTES)-1:0] rd_byte_addr,
    input  logic [7:0]                     rd_byte_data,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [WORD_WIDTH-1:0]          ram_wdata,
    output logic                           ram_wren,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [15:0]                    blocks_loaded
);

    localparam int unsigned BA_W  = $clog2(BLOCK_BYTES);
    localparam int unsigned WPB   = 8 / WORD_WIDTH;
    localparam int unsigned SUB_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BA_W-1:0]  LAST_BYTE = BA_W'(BLOCK_BYTES - 1);
    localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(WPB - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FETCH, LATCH, WRITE, NEXT} state_t;

    state_t                state, state_nx;
    logic                  done_nx, error_nx;
    logic [15:0]           nb_q;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [SUB_W-1:0]      sub_cnt;
    logic [7:0]            sh, src, sh_nx;
    logic [WORD_WIDTH-1:0] wslice;

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state plus the done/error pulses; abort overrides everything.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        error_nx = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (num_blocks == 16'd0) done_nx  = 1'b1;
                else                     state_nx = REQ;
            end
            REQ:  state_nx = WAIT;
            WAIT: if (blk_done) state_nx = FETCH;
                  else if (tmo_cnt == TMO_LAST) begin
                      error_nx = 1'b1;
                      state_nx = IDLE;
                  end
            FETCH: state_nx = LATCH;
            LATCH: state_nx = WRITE;
            WRITE: if (sub_cnt == LAST_SUB)
                       state_nx = (rd_byte_addr == LAST_BYTE) ? NEXT : FETCH;
            NEXT: if (blocks_loaded + 16'd1 == nb_q) begin
                      done_nx  = 1'b1;
                      state_nx = IDLE;
                  end else begin
                      state_nx = REQ;
                  end
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
            error_nx = 1'b0;
        end
    end

    // Slice selection: the fresh byte in LATCH, the shifted remainder in WRITE.
    always_comb begin
        src = (state == LATCH) ? rd_byte_data : sh;
        if (LSB_FIRST) begin
            wslice = src[WORD_WIDTH-1:0];
            sh_nx  = src >> WORD_WIDTH;
        end else begin
            wslice = src[7:8-WORD_WIDTH];
            sh_nx  = src << WORD_WIDTH;
        end
    end

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            blk_id        <= '0;
            blk_execute   <= 1'b0;
            rd_byte_addr  <= '0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_wren      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            blocks_loaded <= '0;
            nb_q          <= '0;
            tmo_cnt       <= '0;
            sub_cnt       <= '0;
            sh            <= '0;
        end else begin
            blk_execute <= (state_nx == REQ);
            busy        <= (state_nx != IDLE);
            ram_wren    <= (state_nx == WRITE);
            done        <= done_nx;
            error       <= error_nx;
            case (state)
                IDLE: if (start && num_blocks != 16'd0) begin
                    nb_q          <= num_blocks;
                    blocks_loaded <= '0;
                    ram_addr      <= base_addr;
                    blk_id        <= first_block;
                end
                REQ:  tmo_cnt <= '0;
                WAIT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (blk_done) rd_byte_addr <= '0;
                end
                LATCH: begin
                    sub_cnt   <= '0;
                    ram_wdata <= wslice;
                    sh        <= sh_nx;
                end
                WRITE: begin
                    ram_addr  <= ram_addr + ADDR_WIDTH'(1);
                    sub_cnt   <= sub_cnt + SUB_W'(1);
                    ram_wdata <= wslice;
                    sh        <= sh_nx;
                    if (sub_cnt == LAST_SUB && rd_byte_addr != LAST_BYTE)
                        rd_byte_addr <= rd_byte_addr + BA_W'(1);
                end
                NEXT: if (!abort) begin
                    blocks_loaded <= blocks_loaded + 16'd1;
                    if (state_nx == REQ) blk_id <= blk_id + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
